// File: rtl/tridiag_pkg.sv
// Shared definitions for the tridiagonal determinant host.
// Holds the host state encoding, the word-count helper, and the section
// bases that give each diagonal its place in the load order: b first, then a, then c.
package tridiag_pkg;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        ACK,
        OUT
    } hostState_t;

    localparam int DEFAULT_N = 16;
    localparam int NUM_WORDS = 3 * DEFAULT_N - 2;
    localparam int B_BASE    = 0;
    localparam int A_BASE    = DEFAULT_N;
    localparam int C_BASE    = 2 * DEFAULT_N - 1;

    function automatic int numWords(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int aBase(input int n);
        return n;
    endfunction

    function automatic int cBase(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/tridiag_coef_buf.sv
// Coefficient buffer for the tridiagonal determinant host.
// Decodes the running word index into b, a or c, and stores each accepted
// word bit-exact at its slot in the flat output vectors.
module tridiag_coef_buf
    import tridiag_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rstN_i,
    input  logic                     wrEn_i,
    input  logic [CNT_W-1:0]         wrIdx_i,
    input  logic [WIDTH-1:0]         wrData_i,
    output logic [WIDTH*(N-1)-1:0]   aFlat_o,
    output logic [WIDTH*N-1:0]       bFlat_o,
    output logic [WIDTH*(N-1)-1:0]   cFlat_o
);

    localparam int A_BASE_N = aBase(N);
    localparam int C_BASE_N = cBase(N);

    logic [WIDTH*(N-1)-1:0] aFlat_q, aFlat_d;
    logic [WIDTH*N-1:0]     bFlat_q, bFlat_d;
    logic [WIDTH*(N-1)-1:0] cFlat_q, cFlat_d;

    // Route the incoming word to the single slot its index selects; everything else holds.
    always_comb begin
        aFlat_d = aFlat_q;
        bFlat_d = bFlat_q;
        cFlat_d = cFlat_q;
        if (wrEn_i) begin
            for (int k = 0; k < N; k++) begin
                if (wrIdx_i == CNT_W'(B_BASE + k)) begin
                    bFlat_d[k*WIDTH +: WIDTH] = wrData_i;
                end
            end
            for (int k = 0; k < N - 1; k++) begin
                if (wrIdx_i == CNT_W'(A_BASE_N + k)) begin
                    aFlat_d[k*WIDTH +: WIDTH] = wrData_i;
                end
                if (wrIdx_i == CNT_W'(C_BASE_N + k)) begin
                    cFlat_d[k*WIDTH +: WIDTH] = wrData_i;
                end
            end
        end
    end

    // Coefficient storage, cleared by reset so a partial load never leaks into the next job.
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            aFlat_q <= '0;
            bFlat_q <= '0;
            cFlat_q <= '0;
        end else begin
            aFlat_q <= aFlat_d;
            bFlat_q <= bFlat_d;
            cFlat_q <= cFlat_d;
        end
    end

    assign aFlat_o = aFlat_q;
    assign bFlat_o = bFlat_q;
    assign cFlat_o = cFlat_q;

endmodule

// File: rtl/tridiag_det_host.sv
// Host wrapper for a tridiagonal determinant engine.
// It streams in 3N-2 coefficient words, pulses start, waits for done, and acknowledges.
// It then presents the captured determinant until the consumer takes it.
// Optional feature: define TRIDIAG_HOST_CYCLE_CNT_EN to add the saturating
// out_cycles latency counter.
module tridiag_det_host
    import tridiag_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     start,
    output logic                     ack,
    output logic [WIDTH*(N-1)-1:0]   a_flat,
    output logic [WIDTH*N-1:0]       b_flat,
    output logic [WIDTH*(N-1)-1:0]   c_flat,
    input  logic                     done,
    input  logic [2*WIDTH-1:0]       det,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_det
`ifdef TRIDIAG_HOST_CYCLE_CNT_EN
    ,
    output logic [15:0]              out_cycles
`endif
);

    localparam int WORDS = numWords(N);
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    hostState_t         state_q, state_d;
    logic [CNT_W-1:0]   wordCnt_q, wordCnt_d;
    logic [2*WIDTH-1:0] outDet_q, outDet_d;
    logic               beat;

    assign beat = in_valid && in_ready;

    // Next-state and handshake outputs; start is held off while the engine still shows done.
    always_comb begin
        state_d   = state_q;
        wordCnt_d = wordCnt_q;
        outDet_d  = outDet_q;
        in_ready  = 1'b0;
        start     = 1'b0;
        ack       = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = rst;
                if (in_valid && rst) begin
                    if (wordCnt_q == LAST_IDX) begin
                        wordCnt_d = '0;
                        state_d   = START;
                    end else begin
                        wordCnt_d = wordCnt_q + 1'b1;
                    end
                end
            end
            START: begin
                start = !done;
                if (!done) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    outDet_d = det;
                    state_d  = ACK;
                end
            end
            ACK: begin
                ack = 1'b1;
                if (!done) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State, word counter and captured result; reset drops any partial load or pending result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LOAD;
            wordCnt_q <= '0;
            outDet_q  <= '0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            outDet_q  <= outDet_d;
        end
    end

    assign out_det = outDet_q;

    tridiag_coef_buf #(
        .N     (N),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_coefBuf (
        .clk_i    (clk),
        .rstN_i   (rst),
        .wrEn_i   (beat),
        .wrIdx_i  (wordCnt_q),
        .wrData_i (in_data),
        .aFlat_o  (a_flat),
        .bFlat_o  (b_flat),
        .cFlat_o  (c_flat)
    );

`ifdef TRIDIAG_HOST_CYCLE_CNT_EN
    logic [15:0] cycles_q, cycles_d;

    // Latency counter: restarts on entry to START, then counts START and engine-busy WAIT cycles.
    always_comb begin
        cycles_d = cycles_q;
        if (state_d == START && state_q != START) begin
            cycles_d = '0;
        end else if ((state_q == START || (state_q == WAIT && !done)) && cycles_q != 16'hFFFF) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign out_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_tridiag_det_host.sv
// Bench for tridiag_det_host: an N=3 and an N=16 host, each paired with a
// behavioural determinant engine built from the flat coefficient outputs.
module tb_tridiag_det_host;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        inValid[2];
    logic [15:0] inData[2];
    logic        inReady[2];
    logic        startP[2];
    logic        ackP[2];
    logic        done[2];
    logic [31:0] det[2];
    logic        outValid[2];
    logic        outReady[2];
    logic [31:0] outDet[2];
    logic [47:0]  bFlat3;
    logic [31:0]  aFlat3, cFlat3;
    logic [255:0] bFlat16;
    logic [239:0] aFlat16, cFlat16;
`ifdef TRIDIAG_HOST_CYCLE_CNT_EN
    logic [15:0] outCycles[2];
`endif

    int totalCnt = 0;
    int passCnt  = 0;

    logic [15:0] bArr[16];
    logic [15:0] aArr[15];
    logic [15:0] cArr[15];

    tridiag_det_host #(.N(3), .WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .start(startP[0]), .ack(ackP[0]), .a_flat(aFlat3), .b_flat(bFlat3), .c_flat(cFlat3),
        .done(done[0]), .det(det[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_det(outDet[0])
`ifdef TRIDIAG_HOST_CYCLE_CNT_EN
        , .out_cycles(outCycles[0])
`endif
    );

    tridiag_det_host #(.N(16), .WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .start(startP[1]), .ack(ackP[1]), .a_flat(aFlat16), .b_flat(bFlat16), .c_flat(cFlat16),
        .done(done[1]), .det(det[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_det(outDet[1])
`ifdef TRIDIAG_HOST_CYCLE_CNT_EN
        , .out_cycles(outCycles[1])
`endif
    );

    // Determinant of a tridiagonal matrix by the continuant recurrence, wrapped to 32 bits.
    function automatic logic [31:0] detCore(input int n, input logic [15:0] b[16],
                                            input logic [15:0] a[15], input logic [15:0] c[15]);
        longint fPrev = 1;
        longint fCur;
        longint fNext;
        fCur = longint'($signed(b[0]));
        for (int k = 1; k < n; k++) begin
            fNext = longint'($signed(b[k])) * fCur
                  - longint'($signed(a[k-1])) * longint'($signed(c[k-1])) * fPrev;
            fPrev = fCur;
            fCur  = fNext;
        end
        return fCur[31:0];
    endfunction

    function automatic logic [31:0] refDet(input int n);
        return detCore(n, bArr, aArr, cArr);
    endfunction

    // What the engine sees: coefficients unpacked from the host's flat outputs.
    function automatic logic [31:0] engineDet(input int e);
        logic [15:0]  eb[16];
        logic [15:0]  ea[15];
        logic [15:0]  ec[15];
        logic [255:0] bf;
        logic [239:0] af;
        logic [239:0] cf;
        bf = (e == 0) ? {208'b0, bFlat3} : bFlat16;
        af = (e == 0) ? {208'b0, aFlat3} : aFlat16;
        cf = (e == 0) ? {208'b0, cFlat3} : cFlat16;
        for (int k = 0; k < 16; k++) eb[k] = bf[k*16 +: 16];
        for (int k = 0; k < 15; k++) begin
            ea[k] = af[k*16 +: 16];
            ec[k] = cf[k*16 +: 16];
        end
        return detCore((e == 0) ? 3 : 16, eb, ea, ec);
    endfunction

    // Word stream order: b[0..n-1], a[0..n-2], c[0..n-2].
    function automatic logic [15:0] wordAt(input int n, input int i);
        if (i < n) return bArr[i];
        else if (i < 2 * n - 1) return aArr[i - n];
        else return cArr[i - 2 * n + 1];
    endfunction

    // Engine model: busy for N-1 cycles after start, then holds done until it sees ack.
    int   engCnt[2];
    logic engBusy[2];
    always @(posedge clk) begin
        for (int e = 0; e < 2; e++) begin
            if (!rst) begin
                done[e]    <= 1'b0;
                engBusy[e] <= 1'b0;
                engCnt[e]  <= 0;
            end else if (startP[e]) begin
                engBusy[e] <= 1'b1;
                engCnt[e]  <= 0;
            end else if (engBusy[e]) begin
                if (engCnt[e] == ((e == 0) ? 1 : 14)) begin
                    done[e]    <= 1'b1;
                    engBusy[e] <= 1'b0;
                    det[e]     <= engineDet(e);
                end else begin
                    engCnt[e] <= engCnt[e] + 1;
                end
            end else if (done[e] && ackP[e]) begin
                done[e] <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Per-cycle protocol monitor plus beat and start-pulse counters.
    logic         prevRst = 1'b0;
    logic         prevBeat[2];
    logic [47:0]  pB3;
    logic [31:0]  pA3, pC3;
    logic [255:0] pB16;
    logic [239:0] pA16, pC16;
    int           beatCnt[2];
    int           startCnt[2];
    initial begin
        for (int e = 0; e < 2; e++) begin
            prevBeat[e] = 1'b0;
            beatCnt[e]  = 0;
            startCnt[e] = 0;
        end
    end
    always @(negedge clk) begin
        for (int e = 0; e < 2; e++) begin
            checkOutput("startWithAck", startP[e] && ackP[e], 0);
            checkOutput("startWhileDone", startP[e] && done[e], 0);
            if (startP[e]) startCnt[e]++;
            if (inValid[e] && inReady[e]) beatCnt[e]++;
        end
        if (prevRst && !prevBeat[0]) checkOutput("flats3Hold", {bFlat3, aFlat3, cFlat3}, {pB3, pA3, pC3});
        if (prevRst && !prevBeat[1]) begin
            checkOutput("bFlat16Hold", bFlat16, pB16);
            checkOutput("acFlat16Hold", {aFlat16, cFlat16}, {pA16, pC16});
        end
        prevRst = rst;
        for (int e = 0; e < 2; e++) prevBeat[e] = inValid[e] && inReady[e];
        pB3 = bFlat3; pA3 = aFlat3; pC3 = cFlat3;
        pB16 = bFlat16; pA16 = aFlat16; pC16 = cFlat16;
    end

    task automatic setUniform(input logic [15:0] b, input logic [15:0] a, input logic [15:0] c);
        for (int k = 0; k < 16; k++) bArr[k] = b;
        for (int k = 0; k < 15; k++) begin
            aArr[k] = a;
            cArr[k] = c;
        end
    endtask

    task automatic setRandom();
        for (int k = 0; k < 16; k++) bArr[k] = 16'($urandom);
        for (int k = 0; k < 15; k++) begin
            aArr[k] = 16'($urandom);
            cArr[k] = 16'($urandom);
        end
    endtask

    // gapMode 0: valid every cycle, 1: every other cycle, 2: random.
    task automatic applyStimulus(input int sel, input int nw, input int gapMode);
        int   n = (sel == 0) ? 3 : 16;
        int   i = 0;
        int   cyc = 0;
        logic v;
        while (i < nw && cyc < 400) begin
            @(posedge clk); #1;
            if (gapMode == 0) v = 1'b1;
            else if (gapMode == 1) v = (cyc % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            inValid[sel] = v;
            inData[sel]  = v ? wordAt(n, i) : 16'($urandom);
            @(negedge clk);
            if (v && inReady[sel]) i++;
            cyc++;
        end
        @(posedge clk); #1;
        inValid[sel] = 1'b0;
    endtask

    task automatic checkFlats(input int sel, input int n);
        logic [255:0] eb = '0;
        logic [255:0] ea = '0;
        logic [255:0] ec = '0;
        for (int k = 0; k < n; k++) eb[k*16 +: 16] = bArr[k];
        for (int k = 0; k < n - 1; k++) begin
            ea[k*16 +: 16] = aArr[k];
            ec[k*16 +: 16] = cArr[k];
        end
        if (sel == 0) begin
            checkOutput("bFlat", {208'b0, bFlat3}, eb);
            checkOutput("aFlat", {224'b0, aFlat3}, ea);
            checkOutput("cFlat", {224'b0, cFlat3}, ec);
        end else begin
            checkOutput("bFlat", bFlat16, eb);
            checkOutput("aFlat", {16'b0, aFlat16}, ea);
            checkOutput("cFlat", {16'b0, cFlat16}, ec);
        end
    endtask

    task automatic runJob(input int sel, input int gapMode, input int hold, input logic [31:0] expDet);
        int n = (sel == 0) ? 3 : 16;
        int b0 = beatCnt[sel];
        int s0 = startCnt[sel];
        int waitCyc = 0;
        applyStimulus(sel, 3 * n - 2, gapMode);
        while (!outValid[sel] && waitCyc < 300) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("outValidReached", outValid[sel], 1);
        checkOutput("beatsAccepted", beatCnt[sel] - b0, 3 * n - 2);
        checkOutput("startPulses", startCnt[sel] - s0, 1);
        checkOutput("outDet", outDet[sel], expDet);
        checkFlats(sel, n);
`ifdef TRIDIAG_HOST_CYCLE_CNT_EN
        checkOutput("outCycles", outCycles[sel], n);
`endif
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("holdValid", outValid[sel], 1);
            checkOutput("holdDet", outDet[sel], expDet);
            checkOutput("holdNotReady", inReady[sel], 0);
        end
        @(posedge clk); #1;
        outReady[sel] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        outReady[sel] = 1'b0;
        @(negedge clk);
        checkOutput("outValidDropped", outValid[sel], 0);
        checkOutput("backToLoad", inReady[sel], 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int e = 0; e < 2; e++) begin
            inValid[e]  = 1'b0;
            inData[e]   = '0;
            outReady[e] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] checking reset state");
        for (int e = 0; e < 2; e++) begin
            checkOutput("rstInReady", inReady[e], 0);
            checkOutput("rstStart", startP[e], 0);
            checkOutput("rstAck", ackP[e], 0);
            checkOutput("rstOutValid", outValid[e], 0);
            checkOutput("rstOutDet", outDet[e], 0);
        end
        checkOutput("rstFlats3", {bFlat3, aFlat3, cFlat3}, 0);
        checkOutput("rstFlats16", {bFlat16, aFlat16}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("firstCycleReady3", inReady[0], 1);
        checkOutput("firstCycleReady16", inReady[1], 1);

        $display("[TB] directed N=3 jobs");
        setUniform(16'd2, 16'd1, 16'd1);
        runJob(0, 0, 0, 32'd4);
        setUniform(16'hFFFF, 16'd0, 16'd0);
        runJob(0, 0, 5, 32'hFFFF_FFFF);

        $display("[TB] N=16 identity with gapped valid");
        setUniform(16'd1, 16'd0, 16'd0);
        runJob(1, 1, 0, 32'd1);

        $display("[TB] reset during WAIT");
        setRandom();
        applyStimulus(0, 7, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstReady", inReady[0], 1);
        checkOutput("midRstStart", startP[0], 0);
        checkOutput("midRstAck", ackP[0], 0);
        checkOutput("midRstOutValid", outValid[0], 0);
        checkOutput("midRstOutDet", outDet[0], 0);
        checkOutput("midRstFlats", {bFlat3, aFlat3, cFlat3}, 0);

        $display("[TB] reset during a partial load");
        setRandom();
        applyStimulus(1, 20, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        setRandom();
        runJob(1, 2, 2, refDet(16));

        $display("[TB] random jobs");
        for (int r = 0; r < 5; r++) begin
            setRandom();
            runJob(0, 2, int'($urandom_range(0, 3)), refDet(3));
        end
        for (int r = 0; r < 3; r++) begin
            setRandom();
            runJob(1, 2, int'($urandom_range(0, 3)), refDet(16));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
